// File: rtl/pss_generator.sv
// NR primary synchronization sequence source: 127 BPSK samples of d_PSS(n) for a
// selected N_id_2, streamed as {im, re} on an AXI-stream master.
module pss_generator #(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 8192,
    parameter int PSS_LEN   = 127
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        N_id_2_i,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic              busy_o,
    output logic              err_o
);

    localparam int HW = OUT_DW / 2;
    localparam logic [6:0] LFSR_INIT = 7'b1110110;
    localparam logic [6:0] LAST_IDX  = 7'(PSS_LEN - 1);
    localparam logic signed [HW-1:0] AMP_POS = HW'(AMPLITUDE);
    localparam logic signed [HW-1:0] AMP_NEG = HW'(-AMPLITUDE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEEK   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]    r_state;
    logic [6:0]    r_lfsr;
    logic [6:0]    r_skip;
    logic [6:0]    r_cnt;
    logic          r_err;
    logic [6:0]    w_lfsr_next;
    logic [6:0]    w_skip_init;
    logic [HW-1:0] w_re;

    // r_lfsr[k] holds x(i+k); x(i) sits in bit 0 and is the sample being offered
    assign w_lfsr_next = {r_lfsr[4] ^ r_lfsr[0], r_lfsr[6:1]};
    assign w_re        = r_lfsr[0] ? AMP_NEG : AMP_POS;

    always_comb begin
        w_skip_init = '0;
        case (N_id_2_i)
            2'd1:    w_skip_init = 7'd43;
            2'd2:    w_skip_init = 7'd86;
            default: w_skip_init = '0;
        endcase
    end

    assign m_axis_out_tvalid = (r_state == S_STREAM);
    assign m_axis_out_tdata  = m_axis_out_tvalid ? {{(OUT_DW-HW){1'b0}}, w_re} : '0;
    assign m_axis_out_tlast  = m_axis_out_tvalid && (r_cnt == LAST_IDX);
    assign busy_o            = (r_state != S_IDLE);
    assign err_o             = r_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_INIT;
            r_skip  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (N_id_2_i == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_lfsr  <= LFSR_INIT;
                            r_skip  <= w_skip_init;
                            r_state <= S_SEEK;
                        end
                    end
                end
                S_SEEK: begin
                    // Cyclic shift by 43*N_id_2 is realised by stepping the LFSR ahead
                    if (r_skip != '0) begin
                        r_lfsr <= w_lfsr_next;
                        r_skip <= r_skip - 7'd1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (m_axis_out_tready) begin
                        r_lfsr <= w_lfsr_next;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pss_generator.sv
// Directed bench for pss_generator: expected samples come from an array-based
// model of the PSS recurrence and are queued, then popped on each handshake.
module tb_pss_generator;

    localparam int OUT_DW = 32;
    localparam int AMP    = 8192;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic [1:0]        N_id_2_i = 2'd0;
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tready = 1'b1;
    logic              tlast;
    logic              busy;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    bit          ref_x[127];
    logic [32:0] q[$];
    logic [31:0] got[127];
    int          neg_cnt;
    int          last_cnt;

    always #5 clk = ~clk;

    pss_generator #(
        .OUT_DW   (OUT_DW),
        .AMPLITUDE(AMP),
        .PSS_LEN  (127)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .N_id_2_i         (N_id_2_i),
        .m_axis_out_tdata (tdata),
        .m_axis_out_tvalid(tvalid),
        .m_axis_out_tready(tready),
        .m_axis_out_tlast (tlast),
        .busy_o           (busy),
        .err_o            (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int nid, input int k);
        logic [15:0] re;
        re = ref_x[(k + 43 * nid) % 127] ? 16'hE000 : 16'h2000;
        return {16'h0000, re};
    endfunction

    // One full request: start in the current IDLE cycle, then step cycle by cycle.
    // inj_at >= 0 pulses a competing start during handshake index inj_at;
    // abort_at >= 0 asserts reset in the cycle of that sample's handshake.
    task automatic run_seq(input string tag, input int nid, input bit rnd,
                           input int inj_at, input int abort_at);
        int          hs;
        int          cyc;
        bit          seen;
        bit          stall_prev;
        bit          done;
        logic [31:0] pd;
        logic        pl;
        logic [32:0] e;
        q.delete();
        for (int k = 0; k < 127; k++) q.push_back({k == 126, smp(nid, k)});
        hs = 0; cyc = 0; seen = 0; stall_prev = 0; done = 0;
        neg_cnt = 0; last_cnt = 0; pd = '0; pl = 1'b0;
        start_i  = 1'b1;
        N_id_2_i = 2'(nid);
        tready   = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 1000) begin
            tready   = rnd ? 1'($urandom % 2) : 1'b1;
            start_i  = (inj_at >= 0 && hs == inj_at);
            N_id_2_i = start_i ? 2'd1 : 2'($urandom);
            @(negedge clk);
            chk({tag, "_err_quiet"}, 64'(err), 64'd0);
            if (tvalid && !seen) begin
                seen = 1;
                chk({tag, "_latency"}, 64'(cyc), 64'(2 + 43 * nid));
            end
            if (stall_prev) begin
                chk({tag, "_stall_valid"}, 64'(tvalid), 64'd1);
                chk({tag, "_stall_data"}, 64'(tdata), 64'(pd));
                chk({tag, "_stall_last"}, 64'(tlast), 64'(pl));
            end
            if (seen && hs < 127) begin
                chk({tag, "_no_gap"}, 64'(tvalid), 64'd1);
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
            if (tvalid && tready) begin
                e = q.pop_front();
                chk({tag, "_data"}, 64'(tdata), 64'(e[31:0]));
                chk({tag, "_last"}, 64'(tlast), 64'(e[32]));
                got[hs] = tdata;
                if (tdata[15:0] == 16'hE000) neg_cnt++;
                if (tlast) last_cnt++;
                if (hs == abort_at) reset_i = 1'b1;
                hs++;
            end
            stall_prev = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            @(posedge clk); #1;
            cyc++;
            if (reset_i) begin
                reset_i = 1'b0;
                chk({tag, "_rst_valid"}, 64'(tvalid), 64'd0);
                chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
                chk({tag, "_rst_data"}, 64'(tdata), 64'd0);
                chk({tag, "_rst_last"}, 64'(tlast), 64'd0);
                q.delete();
                done = 1;
            end else if (hs == 127) begin
                chk({tag, "_end_valid"}, 64'(tvalid), 64'd0);
                chk({tag, "_end_busy"}, 64'(busy), 64'd0);
                chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
                done = 1;
            end
        end
        start_i = 1'b0;
        tready  = 1'b1;
        chk({tag, "_completed"}, 64'(done), 64'd1);
        chk({tag, "_handshakes"}, 64'(hs), 64'(abort_at >= 0 ? abort_at + 1 : 127));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp9[9];
        exp9 = '{8192, -8192, -8192, 8192, -8192, -8192, -8192, -8192, 8192};
        ref_x[0] = 0; ref_x[1] = 1; ref_x[2] = 1; ref_x[3] = 0;
        ref_x[4] = 1; ref_x[5] = 1; ref_x[6] = 1;
        for (int i = 0; i < 120; i++) ref_x[i+7] = ref_x[i+4] ^ ref_x[i];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(tvalid), 64'd0);
        chk("reset_data", 64'(tdata), 64'd0);
        chk("reset_last", 64'(tlast), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        reset_i = 1'b0;
        @(posedge clk); #1;

        run_seq("n0", 0, 1'b0, -1, -1);
        for (int k = 0; k < 9; k++)
            chk("n0_first9", 64'($signed(got[k][15:0])), 64'(exp9[k]));
        for (int k = 0; k < 127; k++)
            chk("n0_im_zero", 64'(got[k][31:16]), 64'd0);
        chk("n0_neg_total", 64'(neg_cnt), 64'd64);
        chk("n0_last_total", 64'(last_cnt), 64'd1);

        run_seq("n1", 1, 1'b0, -1, -1);
        run_seq("n2", 2, 1'b0, -1, -1);
        run_seq("n2_rnd", 2, 1'b1, -1, -1);

        @(posedge clk); #1;
        start_i  = 1'b1;
        N_id_2_i = 2'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("bad_err_pulse", 64'(err), 64'd1);
        chk("bad_busy", 64'(busy), 64'd0);
        chk("bad_valid", 64'(tvalid), 64'd0);
        @(posedge clk); #1;
        chk("bad_err_clear", 64'(err), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bad_idle_valid", 64'(tvalid), 64'd0);
            chk("bad_idle_busy", 64'(busy), 64'd0);
        end

        run_seq("inj", 0, 1'b0, 50, -1);
        run_seq("abort", 0, 1'b0, -1, 60);
        run_seq("rerun", 0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
